// File: rtl/alarm_sequencer.sv
// Alarm panel sequencer: walks DISARMED -> EXIT -> ARMED -> ENTRY -> ALARM
// and drives a shared external timer through load/enable/clear strobes.
// Every output is registered, so a sampled input shows up one clock later.
module alarm_sequencer #(
  parameter logic [17:0] EXIT_TICKS  = 18'd30,
  parameter logic [17:0] ENTRY_TICKS = 18'd15,
  parameter logic [17:0] SIREN_TICKS = 18'd120
) (
  input  logic        clkSignal,
  input  logic        RST,
  input  logic        armReq,
  input  logic        disarmReq,
  input  logic        sensorTrip,
  input  logic        tmrFinish,
  output logic        tmrEN,
  output logic        tmrRST,
  output logic [17:0] tmrMaxCount,
  output logic [2:0]  state,
  output logic        siren,
  output logic        ledArmed,
  output logic        armFault
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  // A zero count would never expire on the timer, so it is forced to 1.
  localparam logic [17:0] LP_EXIT  = (EXIT_TICKS  == 18'd0) ? 18'd1 : EXIT_TICKS;
  localparam logic [17:0] LP_ENTRY = (ENTRY_TICKS == 18'd0) ? 18'd1 : ENTRY_TICKS;
  localparam logic [17:0] LP_SIREN = (SIREN_TICKS == 18'd0) ? 18'd1 : SIREN_TICKS;

  state_t      r_state;
  logic        r_tmr_en;
  logic        r_tmr_rst;
  logic [17:0] r_max;
  logic        r_siren;
  logic        r_led;
  logic        r_fault;

  state_t      w_next;
  logic        w_fault;
  logic        w_fin_ok;
  logic        w_change;
  logic        w_timed;
  logic [17:0] w_max_nxt;

  // An expiry seen while the timer is being cleared belongs to the old load.
  assign w_fin_ok = tmrFinish & ~r_tmr_rst;

  // State register; reset aborts any state, including ALARM.
  always_ff @(posedge clkSignal) begin
    if (!RST) begin
      r_state <= S_DISARMED;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; priority is disarm > expiry > sensor > arm.
  always_comb begin
    w_next  = r_state;
    w_fault = 1'b0;
    case (r_state)
      S_DISARMED: begin
        if (armReq) begin
          if (sensorTrip) begin
            w_fault = 1'b1;
          end else begin
            w_next = S_EXIT;
          end
        end
      end
      S_EXIT: begin
        if (disarmReq) begin
          w_next = S_DISARMED;
        end else if (w_fin_ok) begin
          w_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (disarmReq) begin
          w_next = S_DISARMED;
        end else if (sensorTrip) begin
          w_next = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (disarmReq) begin
          w_next = S_DISARMED;
        end else if (w_fin_ok) begin
          w_next = S_ALARM;
        end
      end
      S_ALARM: begin
        if (disarmReq) begin
          w_next = S_DISARMED;
        end else if (w_fin_ok) begin
          w_next = S_ARMED;
        end
      end
      default: begin
        w_next = S_DISARMED;
      end
    endcase
  end

  // Output decode from the state being entered, so the registered outputs
  // line up with the registered state.
  always_comb begin
    w_change  = (w_next != r_state);
    w_timed   = (w_next == S_EXIT) || (w_next == S_ENTRY) || (w_next == S_ALARM);
    w_max_nxt = r_max;
    if (w_change) begin
      case (w_next)
        S_EXIT:  w_max_nxt = LP_EXIT;
        S_ENTRY: w_max_nxt = LP_ENTRY;
        S_ALARM: w_max_nxt = LP_SIREN;
        default: w_max_nxt = r_max;
      endcase
    end
  end

  // Output registers; the clear pulse marks the first cycle of every new state.
  always_ff @(posedge clkSignal) begin
    if (!RST) begin
      r_tmr_en  <= 1'b0;
      r_tmr_rst <= 1'b1;
      r_max     <= 18'd0;
      r_siren   <= 1'b0;
      r_led     <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_tmr_en  <= w_timed & ~w_change;
      r_tmr_rst <= w_change;
      r_max     <= w_max_nxt;
      r_siren   <= (w_next == S_ALARM);
      r_led     <= (w_next == S_ARMED) || (w_next == S_ENTRY) || (w_next == S_ALARM);
      r_fault   <= w_fault;
    end
  end

  assign state       = r_state;
  assign tmrEN       = r_tmr_en;
  assign tmrRST      = r_tmr_rst;
  assign tmrMaxCount = r_max;
  assign siren       = r_siren;
  assign ledArmed    = r_led;
  assign armFault    = r_fault;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: a vector table with tmrFinish driven
// directly, then timer-model sequences and a zero-parameter clamp check.
module tb_alarm_sequencer;

  logic        clkSignal;
  logic        RST;
  logic        armReq;
  logic        disarmReq;
  logic        sensorTrip;
  logic        vec_fin;
  logic        use_model;
  logic        w_fin;
  logic        tmrEN;
  logic        tmrRST;
  logic [17:0] tmrMaxCount;
  logic [2:0]  state;
  logic        siren;
  logic        ledArmed;
  logic        armFault;

  logic        c_tmrEN;
  logic        c_tmrRST;
  logic [17:0] c_tmrMaxCount;
  logic [2:0]  c_state;
  logic        c_siren;
  logic        c_ledArmed;
  logic        c_armFault;

  logic [17:0] tm_cnt;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rst;
    logic        arm;
    logic        dis;
    logic        trip;
    logic        fin;
    logic [2:0]  st;
    logic        en;
    logic        trst;
    logic [17:0] mx;
    logic        sir;
    logic        led;
    logic        flt;
  } vec_t;

  vec_t vecs[$];

  alarm_sequencer #(
    .EXIT_TICKS (18'd3),
    .ENTRY_TICKS(18'd2),
    .SIREN_TICKS(18'd4)
  ) u_dut (
    .clkSignal  (clkSignal),
    .RST        (RST),
    .armReq     (armReq),
    .disarmReq  (disarmReq),
    .sensorTrip (sensorTrip),
    .tmrFinish  (w_fin),
    .tmrEN      (tmrEN),
    .tmrRST     (tmrRST),
    .tmrMaxCount(tmrMaxCount),
    .state      (state),
    .siren      (siren),
    .ledArmed   (ledArmed),
    .armFault   (armFault)
  );

  alarm_sequencer #(
    .EXIT_TICKS (18'd0),
    .ENTRY_TICKS(18'd0),
    .SIREN_TICKS(18'd0)
  ) u_clamp (
    .clkSignal  (clkSignal),
    .RST        (RST),
    .armReq     (armReq),
    .disarmReq  (disarmReq),
    .sensorTrip (sensorTrip),
    .tmrFinish  (w_fin),
    .tmrEN      (c_tmrEN),
    .tmrRST     (c_tmrRST),
    .tmrMaxCount(c_tmrMaxCount),
    .state      (c_state),
    .siren      (c_siren),
    .ledArmed   (c_ledArmed),
    .armFault   (c_armFault)
  );

  // Clock
  initial clkSignal = 1'b0;
  always #5 clkSignal = ~clkSignal;

  // Shared timer model: clear on tmrRST, count while enabled.
  always @(posedge clkSignal) begin
    if (!RST || tmrRST) tm_cnt <= 18'd0;
    else if (tmrEN)     tm_cnt <= tm_cnt + 18'd1;
  end

  assign w_fin = use_model ? (tmrEN && (tm_cnt >= tmrMaxCount)) : vec_fin;

  task automatic chk(input string name, input int idx, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic arm, input logic dis, input logic trip,
                     input logic fin, input logic [2:0] st, input logic en, input logic trst,
                     input logic [17:0] mx, input logic sir, input logic led, input logic flt);
    vec_t v;
    v.rst = rst; v.arm = arm; v.dis = dis; v.trip = trip; v.fin = fin;
    v.st = st; v.en = en; v.trst = trst; v.mx = mx; v.sir = sir; v.led = led; v.flt = flt;
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    RST = v.rst; armReq = v.arm; disarmReq = v.dis; sensorTrip = v.trip; vec_fin = v.fin;
    @(posedge clkSignal);
    #1;
    chk("state",       idx, 18'(state),    18'(v.st));
    chk("tmrEN",       idx, 18'(tmrEN),    18'(v.en));
    chk("tmrRST",      idx, 18'(tmrRST),   18'(v.trst));
    chk("tmrMaxCount", idx, tmrMaxCount,   v.mx);
    chk("siren",       idx, 18'(siren),    18'(v.sir));
    chk("ledArmed",    idx, 18'(ledArmed), 18'(v.led));
    chk("armFault",    idx, 18'(armFault), 18'(v.flt));
  endtask

  // Wait up to 20 edges for the given state; returns edges taken, or 21.
  task automatic wait_state(input logic [2:0] target, output int cycles);
    cycles = 21;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clkSignal);
      #1;
      if (state == target) begin
        cycles = c;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    n_checks = 0; n_fail = 0;
    RST = 1'b0; armReq = 1'b0; disarmReq = 1'b0; sensorTrip = 1'b0;
    vec_fin = 1'b0; use_model = 1'b0;

    //   rst arm dis trp fin | st en trst mx sir led flt
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);   // reset values
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);   // first released edge drops tmrRST
    add(1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);   // disarm ignored in DISARMED
    add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);   // expiry ignored in DISARMED
    add(1, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1);   // arm refused with sensor open
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);   // fault is a single pulse
    add(1, 1, 0, 0, 0,  1, 0, 1, 3, 0, 0, 0);   // arm -> EXIT, load 3
    add(1, 0, 0, 0, 1,  1, 1, 0, 3, 0, 0, 0);   // stale expiry in clear cycle
    add(1, 0, 0, 1, 0,  1, 1, 0, 3, 0, 0, 0);   // sensor ignored in EXIT
    add(1, 1, 0, 0, 0,  1, 1, 0, 3, 0, 0, 0);   // arm ignored in EXIT
    add(1, 0, 0, 0, 1,  2, 0, 1, 3, 0, 1, 0);   // expiry -> ARMED
    add(1, 0, 0, 0, 1,  2, 0, 0, 3, 0, 1, 0);   // expiry ignored in ARMED
    add(1, 0, 0, 1, 0,  3, 0, 1, 2, 0, 1, 0);   // sensor -> ENTRY, load 2
    add(1, 0, 0, 1, 1,  3, 1, 0, 2, 0, 1, 0);   // stale expiry in clear cycle
    add(1, 0, 0, 0, 1,  4, 0, 1, 4, 1, 1, 0);   // expiry -> ALARM, load 4
    add(1, 0, 0, 1, 0,  4, 1, 0, 4, 1, 1, 0);   // siren running
    add(1, 0, 0, 1, 1,  2, 0, 1, 4, 0, 1, 0);   // siren timeout -> ARMED, hold 4
    add(1, 0, 0, 1, 0,  3, 0, 1, 2, 0, 1, 0);   // sensor still open -> ENTRY
    add(1, 0, 0, 0, 0,  3, 1, 0, 2, 0, 1, 0);
    add(1, 0, 1, 0, 1,  0, 0, 1, 2, 0, 0, 0);   // disarm beats expiry in ENTRY
    add(1, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0);
    add(1, 1, 0, 0, 0,  1, 0, 1, 3, 0, 0, 0);
    add(1, 0, 1, 0, 0,  0, 0, 1, 3, 0, 0, 0);   // disarm from EXIT
    add(1, 1, 0, 0, 0,  1, 0, 1, 3, 0, 0, 0);
    add(1, 0, 0, 0, 0,  1, 1, 0, 3, 0, 0, 0);
    add(1, 0, 0, 0, 1,  2, 0, 1, 3, 0, 1, 0);
    add(1, 1, 0, 0, 0,  2, 0, 0, 3, 0, 1, 0);   // arm ignored in ARMED
    add(1, 0, 1, 0, 0,  0, 0, 1, 3, 0, 0, 0);   // disarm from ARMED
    add(1, 1, 0, 0, 0,  1, 0, 1, 3, 0, 0, 0);
    add(1, 0, 0, 0, 0,  1, 1, 0, 3, 0, 0, 0);
    add(1, 0, 0, 0, 1,  2, 0, 1, 3, 0, 1, 0);
    add(1, 0, 0, 1, 0,  3, 0, 1, 2, 0, 1, 0);
    add(1, 0, 0, 0, 0,  3, 1, 0, 2, 0, 1, 0);
    add(1, 0, 0, 0, 1,  4, 0, 1, 4, 1, 1, 0);
    add(1, 0, 0, 0, 0,  4, 1, 0, 4, 1, 1, 0);
    add(0, 1, 1, 1, 1,  0, 0, 1, 0, 0, 0, 0);   // reset aborts ALARM
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], i);
    end

    // Full cycle with the timer model supplying expiry.
    use_model = 1'b1;
    armReq = 1'b1;
    @(posedge clkSignal);
    #1;
    armReq = 1'b0;
    chk("seq_exit_state", 100, 18'(state), 18'd1);
    chk("seq_exit_max",   100, tmrMaxCount, 18'd3);
    chk("clamp_exit_max", 100, c_tmrMaxCount, 18'd1);
    wait_state(3'd2, cyc);
    chk("seq_exit_cycles", 101, 18'(cyc), 18'd5);
    chk("seq_armed_en",    101, 18'(tmrEN), 18'd0);
    chk("seq_armed_led",   101, 18'(ledArmed), 18'd1);

    sensorTrip = 1'b1;
    @(posedge clkSignal);
    #1;
    sensorTrip = 1'b0;
    chk("seq_entry_state", 102, 18'(state), 18'd3);
    chk("seq_entry_max",   102, tmrMaxCount, 18'd2);
    wait_state(3'd4, cyc);
    chk("seq_entry_cycles", 103, 18'(cyc), 18'd4);
    chk("seq_alarm_siren",  103, 18'(siren), 18'd1);
    chk("seq_alarm_max",    103, tmrMaxCount, 18'd4);
    wait_state(3'd2, cyc);
    chk("seq_alarm_cycles", 104, 18'(cyc), 18'd6);
    chk("seq_armed_siren",  104, 18'(siren), 18'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter EXIT_TICKS, default 18'd30: timer count loaded on entry to EXIT.
REQ-002 Parameter ENTRY_TICKS, default 18'd15: timer count loaded on entry to ENTRY.
REQ-003 Parameter SIREN_TICKS, default 18'd120: timer count loaded on entry to ALARM.
REQ-004 clkSignal  in  1: single system clock; all logic rising-edge.
REQ-005 RST  in  1: reset, synchronous, active-low.
REQ-006 armReq  in  1: one-cycle arm request from keypad.
REQ-007 disarmReq  in  1: one-cycle valid-code pulse from keypad.
REQ-008 sensorTrip  in  1: level, OR of door/PIR sensors, already synchronised.
REQ-009 tmrFinish  in  1: expiry flag from the shared timer's clkFinish.
REQ-010 tmrEN  out  1: timer count enable.
REQ-011 tmrRST  out  1: timer clear, active-high.
REQ-012 tmrMaxCount  out  18: timer terminal count.
REQ-013 state  out  3: current state encoding.
REQ-014 siren  out  1: siren drive.
REQ-015 ledArmed  out  1: armed indicator.
REQ-016 armFault  out  1: one-cycle pulse, arm refused.

Function
REQ-017 The block SHALL implement states DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 SHALL return to DISARMED on the next edge.
REQ-018 All outputs SHALL be registered; response to a sampled input SHALL appear one clock later.
REQ-019 Event priority per cycle SHALL be: disarmReq > tmrFinish > sensorTrip > armReq.
REQ-020 DISARMED: armReq with sensorTrip=0 -> EXIT; armReq with sensorTrip=1 -> stay, armFault=1 for one cycle.
REQ-021 EXIT: tmrFinish -> ARMED; sensorTrip ignored in EXIT.
REQ-022 ARMED: sensorTrip=1 -> ENTRY.
REQ-023 ENTRY: tmrFinish -> ALARM.
REQ-024 ALARM: tmrFinish (siren timeout) -> ARMED; if sensorTrip still 1, ARMED -> ENTRY on the following cycle per REQ-022.
REQ-025 disarmReq in any state other than DISARMED SHALL go to DISARMED; in DISARMED it is ignored; armReq is ignored outside DISARMED.
REQ-026 On each transition into EXIT, ENTRY or ALARM, tmrRST SHALL be 1 for exactly the first cycle in the new state and tmrMaxCount SHALL take the matching parameter in that same cycle, held until the next load.
REQ-027 tmrEN SHALL be 1 in EXIT, ENTRY, ALARM except the tmrRST cycle; 0 in DISARMED and ARMED.
REQ-028 tmrFinish SHALL be ignored in DISARMED, ARMED and in any cycle with tmrRST=1 (stale expiry from previous load).
REQ-029 On transition into DISARMED or ARMED, tmrRST SHALL pulse one cycle; tmrMaxCount SHALL hold its last value.
REQ-030 siren SHALL be 1 only in ALARM; ledArmed SHALL be 1 in ARMED, ENTRY, ALARM.
REQ-031 A parameter value of 0 SHALL be treated as 1; no arithmetic is performed on tmrMaxCount beyond this clamp.

Reset
REQ-032 With RST=0 at a rising edge: state=DISARMED, tmrEN=0, tmrRST=1, tmrMaxCount=0, siren=0, ledArmed=0, armFault=0.
REQ-033 Reset SHALL override all inputs and SHALL abort any state, including mid-ALARM, within one edge.
REQ-034 First edge with RST=1: tmrRST=0, other outputs unchanged until an event.

Verification (EXIT_TICKS=3, ENTRY_TICKS=2, SIREN_TICKS=4, timer model attached)
REQ-035 armReq pulse, sensors idle -> state=1 with tmrRST=1, tmrMaxCount=3 next cycle; after expiry state=2, ledArmed=1, tmrEN=0.
REQ-036 ARMED, sensorTrip=1 -> state=3, tmrMaxCount=2; no disarm -> state=4, siren=1, tmrMaxCount=4; after expiry state=2, siren=0.
REQ-037 ENTRY, disarmReq and tmrFinish same cycle -> state=0, siren never asserted.
REQ-038 DISARMED, armReq with sensorTrip=1 -> armFault=1 one cycle, state stays 0, tmrEN=0.
REQ-039 RST=0 asserted during ALARM -> next edge state=0, siren=0, tmrRST=1, tmrMaxCount=0.
REQ-040 tmrFinish forced high in the tmrRST cycle of EXIT entry -> state remains 1 until a later tmrFinish.
